ram_rr_arbiter: RTL and testbench
=================================

Name: ram_rr_arbiter

Overview:
Round-robin controller that shares one 128x32 single-port RAM (synchronous write, asynchronous read) between N_REQ requesters.
- After reset it sequences a full zero-fill of the memory.
- It then grants at most one read or write per cycle, rotating priority among requesters.
- Sits between client datapaths and the RAM instance, and owns all RAM control pins.

Parameters:
N_REQ, 2, number of requesters (2..8)
Data_width, 32, bits per word
Addr_width, 7, address bits; memory depth = 2**Addr_width

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req  input  N_REQ  per-requester request; held high until granted
req_we  input  N_REQ  per-requester op: 1 = write, 0 = read
req_addr  input  N_REQ*Addr_width  flattened addresses, requester i at bits [i*Addr_width +: Addr_width]
req_wdata  input  N_REQ*Data_width  flattened write data, same packing
gnt  output  N_REQ  one-hot combinational grant; request consumed at the clock edge where gnt[i]=1
rvalid  output  N_REQ  registered one-hot pulse: rdata is valid for requester i
rdata  output  Data_width  registered read data, shared by all requesters
init_done  output  1  high once the zero-fill has completed
ram_we  output  1  RAM write enable
ram_address  output  Addr_width  RAM address
ram_d  output  Data_width  RAM write data
ram_q  input  Data_width  RAM combinational read data

Behaviour:
Clock and reset:
- One clock, clk.
- Reset rst is synchronous and active-high; it is sampled only at the posedge of clk.

Reset values:
- state=INIT, init counter=0, priority pointer=0.
- rvalid=0, rdata=0, init_done=0.
- gnt=0 while in INIT.

State machine (2 states):
- INIT:
  - ram_we=1, ram_address=counter, ram_d=0.
  - Counter increments every cycle.
  - When counter==2**Addr_width-1, the next state is SERVE and init_done goes to 1 on the same edge.
  - Fill takes exactly 128 cycles at default parameters.
  - gnt stays 0 throughout; requests wait.
- SERVE:
  - Stays in SERVE until rst.
  - init_done stays 1.
  - Counter is held.

Arbitration (SERVE, combinational):
- Winner = first i with req[i]=1, scanning pointer, pointer+1, ... mod N_REQ.
- gnt is one-hot for the winner, or all zero if no req.
- RAM pins are muxed from the winner: ram_address=req_addr[w], ram_d=req_wdata[w], ram_we=req_we[w].
- With no winner: ram_we=0, ram_address=0, ram_d=0.
- After any grant, the pointer becomes (w+1) mod N_REQ at the edge. With no grant the pointer is unchanged.

Read path:
- At a granting edge with req_we[w]=0: rdata<=ram_q and rvalid<=onehot(w).
- Latency is 1 cycle from the grant cycle to rvalid.
- rvalid is high for exactly one cycle.
- rdata holds its value until the next read.

Write path:
- The write commits at the granting edge.
- rvalid is not asserted for writes.

Boundary conditions:
- One grant per cycle, however many requests are pending.
- A requester that holds req continuously competes again on the next cycle.
- Read of an address written on the previous cycle returns the new data (the RAM read is asynchronous).
- Read and write to the same address in the same cycle cannot occur (single grant).
- req deasserted without a grant: it is dropped, and no state changes.
- rst during SERVE:
  - Next state is INIT.
  - A pending rvalid is cleared.
  - Memory is re-zeroed over 128 cycles.
  - init_done is 0 until the fill completes.
- rst during INIT: the counter restarts at 0.
- The address wraps only within the INIT counter. The counter never exceeds 2**Addr_width-1.

Decomposition:
- Shared package ram_ctrl_pkg:
  - state encoding constants ST_INIT and ST_SERVE.
  - Default Data_width, Addr_width and N_REQ constants.
- One natural sub-module: rr_pick.
  - Combinational round-robin selector.
  - Inputs: req vector and pointer. Outputs: one-hot grant and winner index.
  - Reusable by other shared-resource controllers.
- The RAM itself is instantiated outside this block.

Test Plan:
- Reset, then idle: init_done rises on the 128th posedge after rst deasserts; every RAM address sees ram_we=1 with ram_d=0; reading address 0x55 afterwards -> rdata=0x00000000, rvalid pulse 1 cycle after the grant.
- Requester 0 writes 0xDEADBEEF to 0x12, then reads 0x12 on the next cycle -> gnt[0] in both cycles; rvalid[0] one cycle after the read grant with rdata=0xDEADBEEF.
- N_REQ=2, both holding req continuously (r0 reads 0x01, r1 reads 0x02) -> grants alternate 0,1,0,1; rvalid alternates with a 1-cycle lag; no cycle has two grants.
- N_REQ=3, pointer=2, req=3'b011 -> gnt=3'b001, pointer becomes 1; then req=3'b111 -> gnt=3'b010.
- req asserted during INIT -> gnt stays 0 until init_done; the first grant is in the first SERVE cycle, to requester 0.
- rst asserted for one cycle while requester 1's read is granted -> rvalid stays 0 on the next cycle; state returns to INIT; a previously written 0xA5A5A5A5 at 0x7F reads 0 after the refill.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for RAM-sharing controllers: default geometry and the
// two-state init/serve encoding.
package ram_ctrl_pkg;

  localparam int DEF_N_REQ      = 2;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 7;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: the first set request at or after ptr
// (modulo N) wins, and its one-hot grant and index are reported.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int c;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Owns the control pins of a single-port RAM: zero-fills it after reset, then
// grants one requester per cycle in round-robin order.
module ram_rr_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int Data_width = DEF_DATA_WIDTH,
  parameter int Addr_width = DEF_ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              req_we,
  input  logic [N_REQ*Addr_width-1:0]   req_addr,
  input  logic [N_REQ*Data_width-1:0]   req_wdata,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              rvalid,
  output logic [Data_width-1:0]         rdata,
  output logic                          init_done,
  output logic                          ram_we,
  output logic [Addr_width-1:0]         ram_address,
  output logic [Data_width-1:0]         ram_d,
  input  logic [Data_width-1:0]         ram_q,
  output state_t                        dbg_state,
  output logic [$clog2(N_REQ)-1:0]      dbg_ptr
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [Addr_width-1:0] CNT_MAX = '1;
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(N_REQ - 1);

  state_t                  state_q, state_d;
  logic [Addr_width-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [N_REQ-1:0]        rvalid_q, rvalid_d;
  logic [Data_width-1:0]   rdata_q, rdata_d;
  logic                    init_done_q, init_done_d;

  logic [N_REQ-1:0]        pick_req;
  logic [N_REQ-1:0]        win_gnt;
  logic [PTR_W-1:0]        win_idx;
  logic                    win_any;

  // Handshake: a requester holds req (with op/addr/data stable) until it sees
  // gnt high; the request is consumed at the rising edge where gnt is high.
  // Reads answer one cycle later with an rvalid pulse; writes are not acked.
  assign pick_req = (state_q == ST_SERVE) ? req : '0;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (PTR_W)
  ) u_pick (
    .req (pick_req),
    .ptr (ptr_q),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  assign gnt = win_gnt;

  always_comb begin
    ram_we      = 1'b0;
    ram_address = '0;
    ram_d       = '0;
    if (state_q == ST_INIT) begin
      ram_we      = 1'b1;
      ram_address = cnt_q;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (win_gnt[i]) begin
          ram_we      = req_we[i];
          ram_address = req_addr[i*Addr_width +: Addr_width];
          ram_d       = req_wdata[i*Data_width +: Data_width];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        // Counter parks at its last value so it never leaves the address range.
        if (cnt_q == CNT_MAX) begin
          state_d     = ST_SERVE;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SERVE: begin
        if (win_any) begin
          ptr_d = (win_idx == PTR_LAST) ? '0 : win_idx + PTR_W'(1);
          if (!ram_we) begin
            rvalid_d = win_gnt;
            rdata_d  = ram_q;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      ptr_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      init_done_q <= init_done_d;
    end
  end

  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign init_done = init_done_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter: a 2-requester and a 3-requester instance,
// each driving its own behavioural RAM (synchronous write, asynchronous read).
module tb_ram_rr_arbiter;
  import ram_ctrl_pkg::*;

  localparam int AW = 7;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0]      req2, we2, gnt2, rvalid2;
  logic [2*AW-1:0] addr2;
  logic [2*DW-1:0] wdata2;
  logic [DW-1:0]   rdata2, ram_d2, ram_q2;
  logic            init_done2, ram_we2;
  logic [AW-1:0]   ram_address2;
  state_t          state2;
  logic [0:0]      ptr2;
  logic [DW-1:0]   mem2 [0:127];

  logic [2:0]      req3, we3, gnt3, rvalid3;
  logic [3*AW-1:0] addr3;
  logic [3*DW-1:0] wdata3;
  logic [DW-1:0]   rdata3, ram_d3, ram_q3;
  logic            init_done3, ram_we3;
  logic [AW-1:0]   ram_address3;
  state_t          state3;
  logic [1:0]      ptr3;
  logic [DW-1:0]   mem3 [0:127];

  always @(posedge clk) if (ram_we2) mem2[ram_address2] <= ram_d2;
  assign ram_q2 = mem2[ram_address2];
  always @(posedge clk) if (ram_we3) mem3[ram_address3] <= ram_d3;
  assign ram_q3 = mem3[ram_address3];

  ram_rr_arbiter #(.N_REQ(2), .Data_width(DW), .Addr_width(AW)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .req_we(we2), .req_addr(addr2),
    .req_wdata(wdata2), .gnt(gnt2), .rvalid(rvalid2), .rdata(rdata2),
    .init_done(init_done2), .ram_we(ram_we2), .ram_address(ram_address2),
    .ram_d(ram_d2), .ram_q(ram_q2), .dbg_state(state2), .dbg_ptr(ptr2)
  );

  ram_rr_arbiter #(.N_REQ(3), .Data_width(DW), .Addr_width(AW)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .req_we(we3), .req_addr(addr3),
    .req_wdata(wdata3), .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3),
    .init_done(init_done3), .ram_we(ram_we3), .ram_address(ram_address3),
    .ram_d(ram_d3), .ram_q(ram_q3), .dbg_state(state3), .dbg_ptr(ptr3)
  );

  task automatic test_reset;
    rst = 1'b1;
    req2 = '0; we2 = '0; addr2 = '0; wdata2 = '0;
    req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (gnt2 !== 2'b00) begin n_errors++; $display("FAIL reset_gnt: got %b want 00", gnt2); end
    n_checks++; if (rvalid2 !== 2'b00) begin n_errors++; $display("FAIL reset_rvalid: got %b want 00", rvalid2); end
    n_checks++; if (rdata2 !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h want 0", rdata2); end
    n_checks++; if (init_done2 !== 1'b0) begin n_errors++; $display("FAIL reset_init_done: got %b want 0", init_done2); end
    n_checks++; if (state2 !== ST_INIT) begin n_errors++; $display("FAIL reset_state: got %0d want INIT", state2); end
    n_checks++; if (ptr2 !== 1'b0) begin n_errors++; $display("FAIL reset_ptr: got %0d want 0", ptr2); end
    n_checks++; if (ram_we2 !== 1'b1 || ram_address2 !== 7'h00) begin n_errors++; $display("FAIL reset_fill_pins: we %b addr %h want 1 00", ram_we2, ram_address2); end
  endtask

  task automatic test_init_fill;
    logic [127:0] seen;
    int bad;
    seen = '0;
    bad  = 0;
    req2 = 2'b01; we2 = 2'b00; addr2[0 +: AW] = 7'h55;
    rst  = 1'b0;
    for (int cyc = 1; cyc <= 128; cyc++) begin
      #1;
      if (gnt2 !== 2'b00 || ram_we2 !== 1'b1 || ram_d2 !== 32'h0 || init_done2 !== 1'b0 ||
          ram_address2 !== AW'(cyc - 1)) bad++;
      seen[ram_address2] = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL fill_cycles: %0d bad cycles want 0", bad); end
    n_checks++; if (seen !== {128{1'b1}}) begin n_errors++; $display("FAIL fill_coverage: got %h want all ones", seen); end
    n_checks++; if (init_done2 !== 1'b1) begin n_errors++; $display("FAIL fill_done_128: got %b want 1", init_done2); end
    n_checks++; if (state2 !== ST_SERVE) begin n_errors++; $display("FAIL fill_state: got %0d want SERVE", state2); end
    n_checks++; if (init_done3 !== 1'b1) begin n_errors++; $display("FAIL fill_done_n3: got %b want 1", init_done3); end
    #1;
    n_checks++; if (gnt2 !== 2'b01) begin n_errors++; $display("FAIL first_grant: got %b want 01", gnt2); end
    n_checks++; if (ram_address2 !== 7'h55 || ram_we2 !== 1'b0) begin n_errors++; $display("FAIL first_grant_pins: addr %h we %b want 55 0", ram_address2, ram_we2); end
    @(negedge clk);
    req2 = 2'b00;
    n_checks++; if (rvalid2 !== 2'b01) begin n_errors++; $display("FAIL read55_rvalid: got %b want 01", rvalid2); end
    n_checks++; if (rdata2 !== 32'h0) begin n_errors++; $display("FAIL read55_rdata: got %h want 0", rdata2); end
    n_checks++; if (ptr2 !== 1'b1) begin n_errors++; $display("FAIL read55_ptr: got %0d want 1", ptr2); end
    @(negedge clk);
    n_checks++; if (rvalid2 !== 2'b00) begin n_errors++; $display("FAIL read55_pulse: got %b want 00", rvalid2); end
  endtask

  task automatic test_write_read;
    req2 = 2'b01; we2 = 2'b01; addr2[0 +: AW] = 7'h12; wdata2[0 +: DW] = 32'hDEADBEEF;
    #1;
    n_checks++; if (gnt2 !== 2'b01) begin n_errors++; $display("FAIL wr_gnt: got %b want 01", gnt2); end
    n_checks++; if (ram_we2 !== 1'b1 || ram_address2 !== 7'h12 || ram_d2 !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL wr_pins: we %b addr %h d %h want 1 12 deadbeef", ram_we2, ram_address2, ram_d2); end
    @(negedge clk);
    we2 = 2'b00;
    #1;
    n_checks++; if (gnt2 !== 2'b01) begin n_errors++; $display("FAIL rd_gnt: got %b want 01", gnt2); end
    n_checks++; if (rvalid2 !== 2'b00) begin n_errors++; $display("FAIL wr_no_rvalid: got %b want 00", rvalid2); end
    @(negedge clk);
    req2 = 2'b00;
    n_checks++; if (rvalid2 !== 2'b01) begin n_errors++; $display("FAIL rd_rvalid: got %b want 01", rvalid2); end
    n_checks++; if (rdata2 !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rd_rdata: got %h want deadbeef", rdata2); end
    @(negedge clk);
    n_checks++; if (rvalid2 !== 2'b00) begin n_errors++; $display("FAIL rd_pulse: got %b want 00", rvalid2); end
    n_checks++; if (rdata2 !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rd_hold: got %h want deadbeef", rdata2); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_g [4];
    exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
    req2 = 2'b11; we2 = 2'b11;
    addr2 = {7'h02, 7'h01}; wdata2 = {32'h22222222, 32'h11111111};
    #1;
    n_checks++; if (gnt2 !== 2'b10) begin n_errors++; $display("FAIL b2b_wr1: got %b want 10", gnt2); end
    @(negedge clk);
    req2 = 2'b01;
    #1;
    n_checks++; if (gnt2 !== 2'b01) begin n_errors++; $display("FAIL b2b_wr0: got %b want 01", gnt2); end
    @(negedge clk);
    req2 = 2'b11; we2 = 2'b00;
    n_checks++; if (rvalid2 !== 2'b00) begin n_errors++; $display("FAIL b2b_wr_rvalid: got %b want 00", rvalid2); end
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (gnt2 !== exp_g[i]) begin n_errors++; $display("FAIL b2b_gnt[%0d]: got %b want %b", i, gnt2, exp_g[i]); end
      @(negedge clk);
      if (i == 3) req2 = 2'b00;
      n_checks++; if (rvalid2 !== exp_g[i]) begin n_errors++; $display("FAIL b2b_rvalid[%0d]: got %b want %b", i, rvalid2, exp_g[i]); end
      n_checks++; if (rdata2 !== (exp_g[i] == 2'b10 ? 32'h22222222 : 32'h11111111)) begin
        n_errors++; $display("FAIL b2b_rdata[%0d]: got %h", i, rdata2); end
    end
    @(negedge clk);
    n_checks++; if (rvalid2 !== 2'b00) begin n_errors++; $display("FAIL b2b_idle: got %b want 00", rvalid2); end
  endtask

  task automatic test_three_req;
    we3 = 3'b000;
    req3 = 3'b010;
    #1;
    n_checks++; if (gnt3 !== 3'b010) begin n_errors++; $display("FAIL n3_setup: got %b want 010", gnt3); end
    @(negedge clk);
    n_checks++; if (ptr3 !== 2'd2) begin n_errors++; $display("FAIL n3_ptr2: got %0d want 2", ptr3); end
    req3 = 3'b011;
    #1;
    n_checks++; if (gnt3 !== 3'b001) begin n_errors++; $display("FAIL n3_wrap: got %b want 001", gnt3); end
    @(negedge clk);
    n_checks++; if (ptr3 !== 2'd1) begin n_errors++; $display("FAIL n3_ptr1: got %0d want 1", ptr3); end
    n_checks++; if (rvalid3 !== 3'b001) begin n_errors++; $display("FAIL n3_rvalid: got %b want 001", rvalid3); end
    req3 = 3'b111;
    #1;
    n_checks++; if (gnt3 !== 3'b010) begin n_errors++; $display("FAIL n3_all_a: got %b want 010", gnt3); end
    @(negedge clk);
    #1;
    n_checks++; if (gnt3 !== 3'b100) begin n_errors++; $display("FAIL n3_all_b: got %b want 100", gnt3); end
    @(negedge clk);
    n_checks++; if (ptr3 !== 2'd0) begin n_errors++; $display("FAIL n3_ptr0: got %0d want 0", ptr3); end
    req3 = 3'b000;
    #1;
    n_checks++; if (gnt3 !== 3'b000) begin n_errors++; $display("FAIL n3_none: got %b want 000", gnt3); end
    @(negedge clk);
    n_checks++; if (ptr3 !== 2'd0 || rvalid3 !== 3'b000) begin
      n_errors++; $display("FAIL n3_hold: ptr %0d rvalid %b want 0 000", ptr3, rvalid3); end
  endtask

  task automatic test_reset_serve;
    int n;
    req2 = 2'b01; we2 = 2'b01; addr2[0 +: AW] = 7'h7F; wdata2[0 +: DW] = 32'hA5A5A5A5;
    @(negedge clk);
    req2 = 2'b10; we2 = 2'b00; addr2[AW +: AW] = 7'h7F;
    @(negedge clk);
    n_checks++; if (rvalid2 !== 2'b10 || rdata2 !== 32'hA5A5A5A5) begin
      n_errors++; $display("FAIL pre_rst_read: rvalid %b rdata %h want 10 a5a5a5a5", rvalid2, rdata2); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req2 = 2'b00;
    n_checks++; if (rvalid2 !== 2'b00) begin n_errors++; $display("FAIL rst_rvalid: got %b want 00", rvalid2); end
    n_checks++; if (state2 !== ST_INIT || init_done2 !== 1'b0) begin
      n_errors++; $display("FAIL rst_state: state %0d done %b want INIT 0", state2, init_done2); end
    repeat (10) @(negedge clk);
    n_checks++; if (ram_address2 !== 7'd10) begin n_errors++; $display("FAIL refill_cnt: got %0d want 10", ram_address2); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (ram_address2 !== 7'd0 || init_done2 !== 1'b0) begin
      n_errors++; $display("FAIL init_rst_cnt: addr %0d done %b want 0 0", ram_address2, init_done2); end
    n = 0;
    while (init_done2 !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_checks++; if (n !== 128) begin n_errors++; $display("FAIL refill_len: got %0d want 128", n); end
    req2 = 2'b10; we2 = 2'b00; addr2[AW +: AW] = 7'h7F;
    #1;
    n_checks++; if (gnt2 !== 2'b10) begin n_errors++; $display("FAIL post_rst_gnt: got %b want 10", gnt2); end
    @(negedge clk);
    req2 = 2'b00;
    n_checks++; if (rvalid2 !== 2'b10 || rdata2 !== 32'h0) begin
      n_errors++; $display("FAIL post_rst_read: rvalid %b rdata %h want 10 0", rvalid2, rdata2); end
  endtask

  initial begin
    test_reset();
    test_init_fill();
    test_write_read();
    test_back_to_back();
    test_three_req();
    test_reset_serve();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
